// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared parameters and state type for the matrix loader/sender pair
//
// Purpose : default matrix geometry and the sender FSM state encoding, shared by
//           every module that produces or consumes the 2-bit matrix stream.
// Ports   : none (package).
package matrix_pkg;

    localparam int DEF_ELEMENT_SIZE = 8;
    localparam int DEF_ROW_LEN      = 32;
    localparam int DEF_NUM_ROWS     = 32;

    // Stream cycles needed for one row at the default geometry.
    localparam int DIBITS_PER_ROW   = DEF_ROW_LEN * DEF_ELEMENT_SIZE / 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROW,
        SHIFT,
        CHKSUM,
        DONE
    } sender_state_t;

endpackage

// File: rtl/matrix_sender.sv
// rtl/matrix_sender.sv - serializes a result matrix row by row onto the 2-bit axiov/axiod stream
//
// Purpose : takes rows from the compute core's result row buffer and sends them
//           to the ethernet TX path, elements in order, MSB dibit first, in the
//           same format the matrix loader consumes.
// Build   : define MATRIX_SENDER_CHECKSUM_EN to append one checksum element
//           (sum mod 2^ELEMENT_SIZE of all sent elements) after the last row.
// Ports   :
//   eth_refclk  in   1                     clock, all logic in this domain
//   rst         in   1                     synchronous active-high reset
//   start       in   1                     pulse; begins a matrix when idle
//   row_valid   in   1                     row_data holds the next row
//   row_data    in   ROW_LEN*ELEMENT_SIZE  row, element 0 in the top bits
//   row_ready   out  1                     row taken when row_valid && row_ready
//   axiov       out  1                     dibit valid
//   axiod       out  2                     dibit
//   busy        out  1                     high whenever not IDLE
//   done        out  1                     one-cycle pulse after the final dibit
module matrix_sender
    import matrix_pkg::*;
#(
    parameter int ELEMENT_SIZE = DEF_ELEMENT_SIZE,
    parameter int ROW_LEN      = DEF_ROW_LEN,
    parameter int NUM_ROWS     = DEF_NUM_ROWS
) (
    input  logic                            eth_refclk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            row_valid,
    input  logic [ROW_LEN*ELEMENT_SIZE-1:0] row_data,
    output logic                            row_ready,
    output logic                            axiov,
    output logic [1:0]                      axiod,
    output logic                            busy,
    output logic                            done
);

    localparam int ROW_BITS = ROW_LEN * ELEMENT_SIZE;
    localparam int DPR      = ROW_BITS / 2;
    localparam int DW       = (DPR > 1) ? $clog2(DPR) : 1;
    localparam int RW       = $clog2(NUM_ROWS) + 1;

    localparam logic [DW-1:0] LAST_DIBIT = DW'(DPR - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(NUM_ROWS - 1);

    sender_state_t         r_state;
    sender_state_t         w_state_next;
    logic [ROW_BITS-1:0]   r_shift;
    logic [DW-1:0]         r_dibit_cnt;
    logic [RW-1:0]         r_row_cnt;
    logic                  w_load_row;
    logic                  w_row_end;
    logic                  w_last_row;

    assign w_row_end  = (r_dibit_cnt == LAST_DIBIT);
    assign w_last_row = (r_row_cnt == LAST_ROW);

`ifdef MATRIX_SENDER_CHECKSUM_EN
    localparam int DPE = ELEMENT_SIZE / 2;
    localparam int EW  = (DPE > 1) ? $clog2(DPE) : 1;
    localparam logic [EW-1:0] LAST_ELEM_DIBIT = EW'(DPE - 1);

    logic [ELEMENT_SIZE-1:0] r_sum;
    logic [ELEMENT_SIZE-1:0] w_sum_next;
    logic [EW-1:0]           r_elem_dibit;
    logic                    w_load_sum;

    // An element is added on its first dibit, while it still sits whole in the
    // top of the shift register. The combinational next value is what gets
    // loaded as the trailer, so the final element is included even when it
    // starts on the row's last dibit.
    always_comb begin
        w_sum_next = r_sum;
        if (r_state == SHIFT && r_elem_dibit == '0) begin
            w_sum_next = r_sum + r_shift[ROW_BITS-1 -: ELEMENT_SIZE];
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_load_row   = 1'b0;
`ifdef MATRIX_SENDER_CHECKSUM_EN
        w_load_sum   = 1'b0;
`endif
        row_ready    = 1'b0;
        axiov        = 1'b0;
        busy         = (r_state != IDLE);
        done         = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = WAIT_ROW;
                end
            end
            WAIT_ROW: begin
                row_ready = 1'b1;
                if (row_valid) begin
                    w_load_row   = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                axiov = 1'b1;
                if (w_row_end) begin
                    if (w_last_row) begin
`ifdef MATRIX_SENDER_CHECKSUM_EN
                        w_load_sum   = 1'b1;
                        w_state_next = CHKSUM;
`else
                        w_state_next = DONE;
`endif
                    end else begin
                        // Offer the next row on the last dibit so a waiting
                        // row continues the stream without a bubble.
                        row_ready = 1'b1;
                        if (row_valid) begin
                            w_load_row = 1'b1;
                        end else begin
                            w_state_next = WAIT_ROW;
                        end
                    end
                end
            end
            CHKSUM: begin
`ifdef MATRIX_SENDER_CHECKSUM_EN
                axiov = 1'b1;
                if (r_elem_dibit == LAST_ELEM_DIBIT) begin
                    w_state_next = DONE;
                end
`else
                w_state_next = IDLE;
`endif
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Gated so the stream lines stay quiet between matrices.
    assign axiod = axiov ? r_shift[ROW_BITS-1 -: 2] : 2'b00;

    always_ff @(posedge eth_refclk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_dibit_cnt <= '0;
            r_row_cnt   <= '0;
        end else begin
            r_state <= w_state_next;

            if (r_state == IDLE && start) begin
                r_row_cnt <= '0;
            end else if (r_state == SHIFT && w_row_end && !w_last_row) begin
                r_row_cnt <= r_row_cnt + RW'(1);
            end

            if (w_load_row) begin
                r_shift     <= row_data;
                r_dibit_cnt <= '0;
            end
`ifdef MATRIX_SENDER_CHECKSUM_EN
            else if (w_load_sum) begin
                r_shift     <= ROW_BITS'(w_sum_next) << (ROW_BITS - ELEMENT_SIZE);
                r_dibit_cnt <= '0;
            end
`endif
            else if (axiov) begin
                r_shift     <= r_shift << 2;
                r_dibit_cnt <= w_row_end ? '0 : r_dibit_cnt + DW'(1);
            end
        end
    end

`ifdef MATRIX_SENDER_CHECKSUM_EN
    always_ff @(posedge eth_refclk) begin
        if (rst) begin
            r_sum        <= '0;
            r_elem_dibit <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_sum <= '0;
            end else if (r_state == SHIFT) begin
                r_sum <= w_sum_next;
            end

            if (w_load_row || w_load_sum) begin
                r_elem_dibit <= '0;
            end else if (axiov) begin
                r_elem_dibit <= (r_elem_dibit == LAST_ELEM_DIBIT) ? '0 : r_elem_dibit + EW'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_matrix_sender.sv
// tb/tb_matrix_sender.sv - directed self-checking bench for matrix_sender
module tb_matrix_sender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // default geometry: 8-bit elements, 32x32
    logic         d_start, d_row_valid, d_row_ready, d_axiov, d_busy, d_done;
    logic [255:0] d_row_data;
    logic [1:0]   d_axiod;
    // 2 elements per row, 1 row
    logic         s1_start, s1_row_valid, s1_row_ready, s1_axiov, s1_busy, s1_done;
    logic [15:0]  s1_row_data;
    logic [1:0]   s1_axiod;
    // 2 elements per row, 2 rows
    logic         s2_start, s2_row_valid, s2_row_ready, s2_axiov, s2_busy, s2_done;
    logic [15:0]  s2_row_data;
    logic [1:0]   s2_axiod;

    int total = 0;
    int bad   = 0;

    matrix_sender #(.ELEMENT_SIZE(8), .ROW_LEN(32), .NUM_ROWS(32)) u_dut (
        .eth_refclk(clk), .rst(rst), .start(d_start), .row_valid(d_row_valid),
        .row_data(d_row_data), .row_ready(d_row_ready), .axiov(d_axiov),
        .axiod(d_axiod), .busy(d_busy), .done(d_done));

    matrix_sender #(.ELEMENT_SIZE(8), .ROW_LEN(2), .NUM_ROWS(1)) u_s1 (
        .eth_refclk(clk), .rst(rst), .start(s1_start), .row_valid(s1_row_valid),
        .row_data(s1_row_data), .row_ready(s1_row_ready), .axiov(s1_axiov),
        .axiod(s1_axiod), .busy(s1_busy), .done(s1_done));

    matrix_sender #(.ELEMENT_SIZE(8), .ROW_LEN(2), .NUM_ROWS(2)) u_s2 (
        .eth_refclk(clk), .rst(rst), .start(s2_start), .row_valid(s2_row_valid),
        .row_data(s2_row_data), .row_ready(s2_row_ready), .axiov(s2_axiov),
        .axiod(s2_axiod), .busy(s2_busy), .done(s2_done));

    // element j of row r in the default-geometry matrices
    function automatic logic [7:0] elem_val(input int r, input int j);
        return 8'(r + j * 9);
    endfunction

    function automatic logic [255:0] mk_row(input int r);
        logic [255:0] v;
        v = '0;
        for (int j = 0; j < 32; j++) v[(31 - j) * 8 +: 8] = elem_val(r, j);
        return v;
    endfunction

    // loader model on the default-geometry stream
    logic       mon_clr;
    int         mon_vc, mon_bub, mon_rr_shift, mon_rr_bad, mon_acc, mon_done, mon_done_nobusy, mon_n;
    logic [7:0] mon_cur;
    logic [7:0] mon_q[$];

    always @(negedge clk) begin
        if (mon_clr) begin
            mon_vc = 0; mon_bub = 0; mon_rr_shift = 0; mon_rr_bad = 0;
            mon_acc = 0; mon_done = 0; mon_done_nobusy = 0; mon_n = 0;
            mon_cur = '0;
            mon_q.delete();
        end else begin
            if (d_row_valid && d_row_ready) mon_acc++;
            if (d_row_ready && d_axiov) begin
                mon_rr_shift++;
                if (mon_vc % 128 != 127) mon_rr_bad++;
            end
            if (d_busy && !d_axiov && !d_done && mon_vc > 0) mon_bub++;
            if (d_axiov) begin
                mon_cur = {mon_cur[5:0], d_axiod};
                mon_n++;
                if (mon_n == 4) begin
                    mon_q.push_back(mon_cur);
                    mon_n = 0;
                end
                mon_vc++;
            end
            if (d_done) begin
                mon_done++;
                if (!d_busy) mon_done_nobusy++;
            end
        end
    end

    task automatic mon_reset();
        mon_clr = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0;
    endtask

    function automatic int elem_errs(input int nelem);
        int e;
        e = 0;
        for (int k = 0; k < nelem; k++) begin
            if (k >= mon_q.size()) e++;
            else if (mon_q[k] !== elem_val(k / 32, k % 32)) e++;
        end
        return e;
    endfunction

    // Feeds rows 0,1,2.. of the default matrix. gap_at/abort_at/start_at are
    // dibit counts seen so far (-1 = unused).
    task automatic drive_matrix(input int gap_at, input int gap_len, input int abort_at,
                                input int start_at, output bit finished);
        int row_idx, gap, cyc, vc;
        bit hs, gap_done, sawv;
        row_idx = 0; gap = 0; cyc = 0; vc = 0; gap_done = 0; finished = 0;
        d_row_data = mk_row(0); d_row_valid = 1'b1; d_start = 1'b1;
        @(posedge clk); #1;
        d_start = 1'b0;
        while (!finished && cyc < 6000) begin
            @(negedge clk);
            hs   = d_row_valid && d_row_ready;
            sawv = d_axiov;
            if (d_axiov) vc++;
            if (d_done) finished = 1;
            @(posedge clk); #1;
            cyc++;
            d_start = (start_at >= 0 && sawv && vc == start_at);
            if (hs) begin
                row_idx++;
                d_row_data = mk_row(row_idx);
            end
            if (gap > 0) begin
                gap--;
                if (gap == 0) d_row_valid = 1'b1;
            end else if (!gap_done && gap_at >= 0 && vc == gap_at) begin
                gap_done = 1; gap = gap_len; d_row_valid = 1'b0;
            end
            if (abort_at >= 0 && vc == abort_at) begin
                rst = 1'b1;
                return;
            end
        end
        d_row_valid = 1'b0;
        d_start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({d_row_ready, d_axiov, d_axiod, d_busy, d_done} !== 6'b0) begin
            bad++; $display("FAIL reset_dflt got=%b exp=000000", {d_row_ready, d_axiov, d_axiod, d_busy, d_done});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({s1_row_ready, s1_axiov, s1_axiod, s1_busy, s1_done} !== 6'b0) begin
            bad++; $display("FAIL reset_s1 got=%b exp=000000", {s1_row_ready, s1_axiov, s1_axiod, s1_busy, s1_done});
        end
        total++;
        if ({s2_row_ready, s2_axiov, s2_axiod, s2_busy, s2_done} !== 6'b0) begin
            bad++; $display("FAIL reset_s2 got=%b exp=000000", {s2_row_ready, s2_axiov, s2_axiod, s2_busy, s2_done});
        end
    endtask

    task automatic test_single_row();
        logic [1:0] exp [8];
        bit got;
        exp = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd3, 2'd3, 2'd0};
        s1_row_data = 16'hA53C; s1_row_valid = 1'b1; s1_start = 1'b1;
        @(posedge clk); #1;
        s1_start = 1'b0;
        got = 0;
        for (int w = 0; w < 10 && !got; w++) begin
            @(negedge clk);
            if (s1_row_valid && s1_row_ready) got = 1;
        end
        total++;
        if (!got) begin bad++; $display("FAIL single_accept got=0 exp=1"); end
        @(posedge clk); #1;
        s1_row_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (s1_axiov !== 1'b1 || s1_axiod !== exp[i]) begin
                bad++; $display("FAIL single_dibit%0d got=v%b d%0d exp=v1 d%0d", i, s1_axiov, s1_axiod, exp[i]);
            end
        end
        @(negedge clk);
        total++;
        if (s1_done !== 1'b1 || s1_axiov !== 1'b0 || s1_busy !== 1'b1) begin
            bad++; $display("FAIL single_done got=d%b v%b b%b exp=d1 v0 b1", s1_done, s1_axiov, s1_busy);
        end
        @(negedge clk);
        total++;
        if (s1_done !== 1'b0 || s1_busy !== 1'b0) begin
            bad++; $display("FAIL single_idle got=d%b b%b exp=d0 b0", s1_done, s1_busy);
        end
    endtask

    task automatic test_two_rows();
        logic [1:0] got_q[$];
        logic [1:0] exp_q[$];
        logic [7:0] el [$];
        logic [7:0] e;
        int hs_n, rr_last, bub;
        bit fin, hs;
        el = '{8'hFF, 8'h02, 8'h10, 8'h01};
`ifdef MATRIX_SENDER_CHECKSUM_EN
        el.push_back(8'h12);
`endif
        foreach (el[k]) begin
            e = el[k];
            exp_q.push_back(e[7:6]); exp_q.push_back(e[5:4]);
            exp_q.push_back(e[3:2]); exp_q.push_back(e[1:0]);
        end
        hs_n = 0; rr_last = 0; bub = 0; fin = 0;
        s2_row_data = 16'hFF02; s2_row_valid = 1'b1; s2_start = 1'b1;
        @(posedge clk); #1;
        s2_start = 1'b0;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            if (s2_axiov) got_q.push_back(s2_axiod);
            if (s2_row_ready && s2_axiov) rr_last++;
            if (s2_busy && !s2_axiov && !s2_done && got_q.size() > 0) bub++;
            hs = s2_row_valid && s2_row_ready;
            if (s2_done) fin = 1;
            @(posedge clk); #1;
            if (hs) begin
                hs_n++;
                if (hs_n == 1) s2_row_data = 16'h1001;
                else s2_row_valid = 1'b0;
            end
        end
        s2_row_valid = 1'b0;
        total++;
        if (!fin) begin bad++; $display("FAIL two_done got=0 exp=1"); end
        total++;
        if (got_q.size() !== exp_q.size()) begin
            bad++; $display("FAIL two_len got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total++;
            if (got_q[k] !== exp_q[k]) begin
                bad++; $display("FAIL two_dibit%0d got=%0d exp=%0d", k, got_q[k], exp_q[k]);
            end
        end
        total++;
        if (hs_n !== 2 || rr_last !== 1 || bub !== 0) begin
            bad++; $display("FAIL two_b2b got=acc%0d rr%0d bub%0d exp=acc2 rr1 bub0", hs_n, rr_last, bub);
        end
    endtask

    task automatic check_full(input string tag, input bit fin, input int exp_bub);
        int e;
        total++;
        if (!fin) begin bad++; $display("FAIL %s_finish got=0 exp=1", tag); end
        total++;
        if (mon_vc !== 4096) begin bad++; $display("FAIL %s_vcount got=%0d exp=4096", tag, mon_vc); end
        total++;
        if (mon_bub !== exp_bub) begin bad++; $display("FAIL %s_bubbles got=%0d exp=%0d", tag, mon_bub, exp_bub); end
        total++;
        if (mon_rr_shift !== 31 || mon_rr_bad !== 0) begin
            bad++; $display("FAIL %s_rowready got=%0d off%0d exp=31 off0", tag, mon_rr_shift, mon_rr_bad);
        end
        total++;
        if (mon_done !== 1 || mon_done_nobusy !== 0) begin
            bad++; $display("FAIL %s_done got=%0d nobusy%0d exp=1 nobusy0", tag, mon_done, mon_done_nobusy);
        end
        total++;
        if (mon_acc !== 32) begin bad++; $display("FAIL %s_accepts got=%0d exp=32", tag, mon_acc); end
        e = elem_errs(1024);
        total++;
        if (e !== 0 || mon_q.size() !== 1024) begin
            bad++; $display("FAIL %s_data got=%0d errs %0d elems exp=0 errs 1024 elems", tag, e, mon_q.size());
        end
        @(negedge clk);
        total++;
        if (d_busy !== 1'b0 || d_done !== 1'b0) begin
            bad++; $display("FAIL %s_after got=b%b d%b exp=b0 d0", tag, d_busy, d_done);
        end
    endtask

    task automatic test_full_matrix();
        bit fin;
        mon_reset();
        drive_matrix(-1, 0, -1, -1, fin);
        check_full("full", fin, 0);
    endtask

    task automatic test_row_stall();
        bit fin;
        mon_reset();
        drive_matrix(511, 5, -1, -1, fin);
        check_full("stall", fin, 5);
    endtask

    task automatic test_reset_mid_matrix();
        bit fin;
        mon_reset();
        drive_matrix(-1, 0, 7 * 128 + 60, -1, fin);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (d_axiov !== 1'b0 || d_busy !== 1'b0 || d_row_ready !== 1'b0) begin
            bad++; $display("FAIL abort_idle got=v%b b%b r%b exp=v0 b0 r0", d_axiov, d_busy, d_row_ready);
        end
        total++;
        if (mon_vc !== 7 * 128 + 61) begin
            bad++; $display("FAIL abort_vcount got=%0d exp=%0d", mon_vc, 7 * 128 + 61);
        end
        repeat (20) @(negedge clk);
        total++;
        if (mon_done !== 0) begin bad++; $display("FAIL abort_nodone got=%0d exp=0", mon_done); end
        d_row_valid = 1'b0;
        mon_reset();
        drive_matrix(-1, 0, -1, -1, fin);
        check_full("rerun", fin, 0);
    endtask

    task automatic test_ignored_inputs();
        bit fin;
        int rr_idle, busy_after;
        mon_reset();
        d_row_data = mk_row(40); d_row_valid = 1'b1;
        rr_idle = 0;
        repeat (10) begin
            @(negedge clk);
            if (d_row_ready || d_busy) rr_idle++;
        end
        total++;
        if (rr_idle !== 0 || mon_acc !== 0) begin
            bad++; $display("FAIL idle_rowvalid got=%0d ready %0d acc exp=0 ready 0 acc", rr_idle, mon_acc);
        end
        mon_reset();
        drive_matrix(-1, 0, -1, 1000, fin);
        check_full("busystart", fin, 0);
        busy_after = 0;
        repeat (5) begin
            @(negedge clk);
            if (d_busy) busy_after++;
        end
        total++;
        if (busy_after !== 0) begin bad++; $display("FAIL busystart_idle got=%0d exp=0", busy_after); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mon_clr = 1'b1;
        d_start = 1'b0;  d_row_valid = 1'b0;  d_row_data = '0;
        s1_start = 1'b0; s1_row_valid = 1'b0; s1_row_data = '0;
        s2_start = 1'b0; s2_row_valid = 1'b0; s2_row_data = '0;
        test_reset();
        test_single_row();
        test_two_rows();
        test_full_matrix();
        test_row_stall();
        test_reset_mid_matrix();
        test_ignored_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
